// File: rtl/cmd_executor_pkg.sv
// Shared constants for the command executor: opcodes, reply headers,
// error codes, special read indices and the controller state encoding.
package cmd_executor_pkg;

    // Command opcodes (byte 0 of a received payload)
    localparam logic [7:0] OP_PING  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;

    // Reply header bytes (byte 0 of a transmitted payload)
    localparam logic [7:0] RSP_ERR   = 8'h80;
    localparam logic [7:0] RSP_PING  = 8'h81;
    localparam logic [7:0] RSP_WRITE = 8'h82;
    localparam logic [7:0] RSP_READ  = 8'h83;

    // Error codes carried in byte 1 of an error reply; 0 means "no error"
    localparam logic [7:0] ERR_NONE = 8'h00;
    localparam logic [7:0] ERR_RX   = 8'h01;
    localparam logic [7:0] ERR_LEN  = 8'h02;
    localparam logic [7:0] ERR_IDX  = 8'h03;
    localparam logic [7:0] ERR_OP   = 8'h04;

    // Read index map: status words start at 0x80, 0xFF returns drop_count
    localparam logic [7:0] STATUS_BASE = 8'h80;
    localparam logic [7:0] DROP_IDX    = 8'hFF;

    // Minimum payload lengths per command
    localparam logic [7:0] LEN_MIN_WRITE = 8'd6;
    localparam logic [7:0] LEN_MIN_READ  = 8'd2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DECODE  = 2'd1,
        S_EXEC    = 2'd2,
        S_WAIT_TX = 2'd3
    } state_t;

    // Saturating 16-bit increment used by the drop counter
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/cmd_executor_reg_bank.sv
// Control register bank: NUM_REGS writable 32-bit registers with a
// one-cycle write strobe per register, plus the read mux that also
// covers the read-only status words and the drop counter.
module cmd_reg_bank
    import cmd_executor_pkg::*;
#(
    parameter int  NUM_REGS   = 32,
    parameter int  NUM_STATUS = 8,
    localparam int ST_W       = (NUM_STATUS > 0) ? NUM_STATUS : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_en,
    input  logic [7:0]               i_wr_idx,
    input  logic [31:0]              i_wr_data,
    input  logic [7:0]               i_rd_idx,
    input  logic [32*ST_W-1:0]       i_status,
    input  logic [15:0]              i_drop_count,
    output logic [32*NUM_REGS-1:0]   o_regs,
    output logic [NUM_REGS-1:0]      o_wr_stb,
    output logic [31:0]              o_rd_data
);

    logic [31:0]         r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_wr_stb;
    logic [31:0]         w_rd_data;

    // Register write port; the strobe is registered alongside the data so
    // both become visible in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 32'd0;
            end
            r_wr_stb <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i_wr_en && (i_wr_idx == 8'(i))) begin
                    r_regs[i]   <= i_wr_data;
                    r_wr_stb[i] <= 1'b1;
                end else begin
                    r_wr_stb[i] <= 1'b0;
                end
            end
        end
    end

    // Flatten the register array onto the packed output bus
    always_comb begin
        o_regs = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            o_regs[32*i +: 32] = r_regs[i];
        end
    end

    // Read mux over control registers, status words and the drop counter;
    // indices that hit nothing read as zero (the decoder rejects them anyway)
    always_comb begin
        w_rd_data = 32'd0;
        if (i_rd_idx == DROP_IDX) begin
            w_rd_data = {16'd0, i_drop_count};
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                w_rd_data = (i_rd_idx == 8'(i)) ? r_regs[i] : w_rd_data;
            end
            for (int i = 0; i < NUM_STATUS; i++) begin
                w_rd_data = (i_rd_idx == (STATUS_BASE + 8'(i))) ? i_status[32*i +: 32] : w_rd_data;
            end
        end
    end

    assign o_wr_stb  = r_wr_stb;
    assign o_rd_data = w_rd_data;

endmodule

// File: rtl/cmd_executor.sv
// Command executor: decodes rx command packets (ping / write / read),
// updates the control register bank and hands exactly one reply per
// accepted command to the tx packetiser. Packets arriving while a command
// is in flight are dropped and counted.
module cmd_executor
    import cmd_executor_pkg::*;
#(
    parameter int  NUM_REGS   = 32,
    parameter int  NUM_STATUS = 8,
    parameter int  BUF_BYTES  = 16,
    localparam int ST_W       = (NUM_STATUS > 0) ? NUM_STATUS : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_packet_done,
    input  logic                     rx_packet_error,
    input  logic [7:0]               rx_payload_len,
    input  logic [8*BUF_BYTES-1:0]   rx_buf,
    input  logic [32*ST_W-1:0]       status_in,
    input  logic                     tx_done,
    output logic                     tx_packet_wr,
    output logic [7:0]               tx_payload_len,
    output logic [8*BUF_BYTES-1:0]   tx_buf,
    output logic [32*NUM_REGS-1:0]   out_regs,
    output logic [NUM_REGS-1:0]      out_wr_stb,
    output logic [15:0]              drop_count
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [7:0]             r_len;
    logic [47:0]            r_hdr;       // bytes 0..5 of the accepted payload
    logic [7:0]             r_err;       // ERR_NONE or the error to report
    logic                   r_tx_wr;
    logic [7:0]             r_tx_len;
    logic [8*BUF_BYTES-1:0] r_tx_buf;
    logic [15:0]            r_drop;

    logic [7:0]             w_op;
    logic [7:0]             w_idx;
    logic [8:0]             w_idx_ext;
    logic [31:0]            w_wr_data;
    logic                   w_idx_is_reg;
    logic                   w_idx_is_status;
    logic [7:0]             w_dec_err;
    logic                   w_wr_en;
    logic [31:0]            w_rd_data;
    logic [7:0]             w_tx_len;
    logic [8*BUF_BYTES-1:0] w_tx_buf;

    assign w_op      = r_hdr[7:0];
    assign w_idx     = r_hdr[15:8];
    assign w_idx_ext = {1'b0, w_idx};
    // Data bytes arrive big-endian: byte 2 is the MSB
    assign w_wr_data = {r_hdr[23:16], r_hdr[31:24], r_hdr[39:32], r_hdr[47:40]};

    // Index classification done in 9 bits so the status window can never wrap
    assign w_idx_is_reg    = (w_idx_ext < 9'(NUM_REGS));
    assign w_idx_is_status = (w_idx_ext >= 9'(STATUS_BASE)) &&
                             (w_idx_ext < (9'(STATUS_BASE) + 9'(NUM_STATUS)));

    assign w_wr_en = (r_state == S_EXEC) && (r_err == ERR_NONE) && (w_op == OP_WRITE);

    // Only payload bytes 0..5 carry command content
    generate
        if (BUF_BYTES > 6) begin : g_rx_tail
            logic w_unused_rx_tail;
            assign w_unused_rx_tail = ^rx_buf[8*BUF_BYTES-1:48];
        end
    endgenerate

    cmd_reg_bank #(
        .NUM_REGS   (NUM_REGS),
        .NUM_STATUS (NUM_STATUS)
    ) u_reg_bank (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wr_en      (w_wr_en),
        .i_wr_idx     (w_idx),
        .i_wr_data    (w_wr_data),
        .i_rd_idx     (w_idx),
        .i_status     (status_in),
        .i_drop_count (r_drop),
        .o_regs       (out_regs),
        .o_wr_stb     (out_wr_stb),
        .o_rd_data    (w_rd_data)
    );

    // Controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a corrupt packet skips decode and goes straight to
    // reply, and wins over a simultaneous valid packet
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (rx_packet_error) begin
                    w_next_state = S_EXEC;
                end else if (rx_packet_done) begin
                    w_next_state = S_DECODE;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_DECODE:  w_next_state = S_EXEC;
            S_EXEC:    w_next_state = S_WAIT_TX;
            S_WAIT_TX: begin
                if (tx_done) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_WAIT_TX;
                end
            end
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Command validation: length 0 is always "too short", otherwise an
    // unknown opcode is reported before any length or index problem
    always_comb begin
        w_dec_err = ERR_NONE;
        if (r_len == 8'd0) begin
            w_dec_err = ERR_LEN;
        end else begin
            case (w_op)
                OP_PING:  w_dec_err = ERR_NONE;
                OP_WRITE: begin
                    if (r_len < LEN_MIN_WRITE) begin
                        w_dec_err = ERR_LEN;
                    end else if (!w_idx_is_reg) begin
                        w_dec_err = ERR_IDX;
                    end else begin
                        w_dec_err = ERR_NONE;
                    end
                end
                OP_READ: begin
                    if (r_len < LEN_MIN_READ) begin
                        w_dec_err = ERR_LEN;
                    end else if (!(w_idx_is_reg || w_idx_is_status || (w_idx == DROP_IDX))) begin
                        w_dec_err = ERR_IDX;
                    end else begin
                        w_dec_err = ERR_NONE;
                    end
                end
                default:  w_dec_err = ERR_OP;
            endcase
        end
    end

    // Reply formation from the decoded result; read data is taken live
    // from the bank so it reflects the value present during execution
    always_comb begin
        w_tx_len = 8'd0;
        w_tx_buf = '0;
        if (r_err != ERR_NONE) begin
            w_tx_len        = 8'd2;
            w_tx_buf[15:0]  = {r_err, RSP_ERR};
        end else begin
            case (w_op)
                OP_PING: begin
                    w_tx_len       = 8'd1;
                    w_tx_buf[7:0]  = RSP_PING;
                end
                OP_WRITE: begin
                    w_tx_len       = 8'd2;
                    w_tx_buf[15:0] = {w_idx, RSP_WRITE};
                end
                OP_READ: begin
                    w_tx_len       = 8'd6;
                    w_tx_buf[47:0] = {w_rd_data[7:0], w_rd_data[15:8], w_rd_data[23:16],
                                      w_rd_data[31:24], w_idx, RSP_READ};
                end
                default: begin
                    w_tx_len       = 8'd2;
                    w_tx_buf[15:0] = {ERR_OP, RSP_ERR};
                end
            endcase
        end
    end

    // Decode latches: capture the packet on acceptance, then the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len <= 8'd0;
            r_hdr <= 48'd0;
            r_err <= ERR_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (rx_packet_error) begin
                        r_err <= ERR_RX;
                    end else if (rx_packet_done) begin
                        r_len <= rx_payload_len;
                        r_hdr <= rx_buf[47:0];
                        r_err <= ERR_NONE;
                    end
                end
                S_DECODE: r_err <= w_dec_err;
                default:  r_err <= r_err;
            endcase
        end
    end

    // Reply registers: loaded and announced once per command, held until
    // the next command executes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_wr  <= 1'b0;
            r_tx_len <= 8'd0;
            r_tx_buf <= '0;
        end else if (r_state == S_EXEC) begin
            r_tx_wr  <= 1'b1;
            r_tx_len <= w_tx_len;
            r_tx_buf <= w_tx_buf;
        end else begin
            r_tx_wr  <= 1'b0;
        end
    end

    // Busy-drop counter: any rx event outside idle is discarded and counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= 16'd0;
        end else if ((r_state != S_IDLE) && (rx_packet_done || rx_packet_error)) begin
            r_drop <= sat_inc16(r_drop);
        end else begin
            r_drop <= r_drop;
        end
    end

    assign tx_packet_wr   = r_tx_wr;
    assign tx_payload_len = r_tx_len;
    assign tx_buf         = r_tx_buf;
    assign drop_count     = r_drop;

endmodule

// File: tb/tb_cmd_executor.sv
// Self-checking bench for cmd_executor: a transaction-level reference model
// predicts each reply, register image and drop count; one compare process
// checks the DUT against it every cycle, with directed literal checks and
// randomized command traffic.
module tb_cmd_executor;

    localparam int NR = 32;
    localparam int NS = 8;
    localparam int BB = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_packet_done = 1'b0;
    logic              rx_packet_error = 1'b0;
    logic [7:0]        rx_payload_len = 8'd0;
    logic [8*BB-1:0]   rx_buf = '0;
    logic [32*NS-1:0]  status_in = '0;
    logic              tx_done = 1'b0;
    logic              tx_packet_wr;
    logic [7:0]        tx_payload_len;
    logic [8*BB-1:0]   tx_buf;
    logic [32*NR-1:0]  out_regs;
    logic [NR-1:0]     out_wr_stb;
    logic [15:0]       drop_count;

    cmd_executor #(.NUM_REGS(NR), .NUM_STATUS(NS), .BUF_BYTES(BB)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_packet_done  (rx_packet_done),
        .rx_packet_error (rx_packet_error),
        .rx_payload_len  (rx_payload_len),
        .rx_buf          (rx_buf),
        .status_in       (status_in),
        .tx_done         (tx_done),
        .tx_packet_wr    (tx_packet_wr),
        .tx_payload_len  (tx_payload_len),
        .tx_buf          (tx_buf),
        .out_regs        (out_regs),
        .out_wr_stb      (out_wr_stb),
        .drop_count      (drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0]     m_regs [NR];
    logic [15:0]     m_drop;
    logic [7:0]      m_tx_len;
    logic [8*BB-1:0] m_tx_buf;
    int              due = -1;       // cycle at which the pending reply appears
    logic [7:0]      p_len;
    logic [8*BB-1:0] p_buf;
    bit              p_wr;
    int              p_idx;
    logic [31:0]     p_data;
    bit              checking = 1'b0;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 32'd0;
        m_drop   = 16'd0;
        m_tx_len = 8'd0;
        m_tx_buf = '0;
        due      = -1;
        p_wr     = 1'b0;
    endtask

    // Predict the reply of one accepted packet from the command rules
    task automatic model_cmd(input bit err, input logic [7:0] len, input logic [7:0] b [6]);
        logic [7:0]  q[$];
        logic [31:0] d;
        int          ix;
        bit          ok;
        p_wr = 1'b0;
        ix   = int'(b[1]);
        d    = 32'd0;
        ok   = 1'b1;
        if (err)                 q = '{8'h80, 8'h01};
        else if (len == 8'd0)    q = '{8'h80, 8'h02};
        else if (b[0] == 8'h01)  q = '{8'h81};
        else if (b[0] == 8'h02) begin
            if (len < 8'd6)      q = '{8'h80, 8'h02};
            else if (ix >= NR)   q = '{8'h80, 8'h03};
            else begin
                p_wr = 1'b1; p_idx = ix; p_data = {b[2], b[3], b[4], b[5]};
                q = '{8'h82, b[1]};
            end
        end else if (b[0] == 8'h03) begin
            if (len < 8'd2)      q = '{8'h80, 8'h02};
            else begin
                if (ix < NR)                          d = m_regs[ix];
                else if (ix >= 128 && ix < 128 + NS)  d = status_in[32*(ix-128) +: 32];
                else if (ix == 255)                   d = {16'h0, m_drop};
                else                                  ok = 1'b0;
                if (ok) q = '{8'h83, b[1], d[31:24], d[23:16], d[15:8], d[7:0]};
                else    q = '{8'h80, 8'h03};
            end
        end else                 q = '{8'h80, 8'h04};
        p_len = 8'(q.size());
        p_buf = '0;
        foreach (q[i]) p_buf[8*i +: 8] = q[i];
    endtask

    // ---------------- compare process ----------------
    initial begin : cmp
        logic [NR-1:0] estb;
        int            bad;
        forever begin
            @(negedge clk);
            if (rst_n && checking) begin
                estb = '0;
                if (cyc == due) begin
                    m_tx_len = p_len;
                    m_tx_buf = p_buf;
                    if (p_wr) begin
                        m_regs[p_idx] = p_data;
                        estb[p_idx]   = 1'b1;
                    end
                end
                chk("tx_packet_wr", tx_packet_wr, cyc == due);
                chk("tx_payload_len", tx_payload_len, m_tx_len);
                chk("tx_buf", tx_buf, m_tx_buf);
                chk("out_wr_stb", out_wr_stb, estb);
                chk("drop_count", drop_count, m_drop);
                bad = 0;
                for (int i = 0; i < NR; i++) begin
                    if (out_regs[32*i +: 32] !== m_regs[i]) begin
                        bad = i;
                        break;
                    end
                end
                chk($sformatf("out_regs[%0d]", bad), out_regs[32*bad +: 32], m_regs[bad]);
            end
        end
    end

    // ---------------- drivers ----------------
    // Present one packet in idle and return in the cycle its reply is visible
    task automatic send(input bit err, input bit dn, input logic [7:0] len,
                        input logic [7:0] b [6], input bit stray_tx);
        logic [8*BB-1:0] v;
        @(posedge clk); #1;
        model_cmd(err, len, b);
        due = cyc + (err ? 2 : 3);
        v = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 6; i++) v[8*i +: 8] = b[i];
        rx_buf          = v;
        rx_payload_len  = len;
        rx_packet_done  = dn;
        rx_packet_error = err;
        tx_done         = stray_tx;
        @(posedge clk); #1;
        rx_packet_done  = 1'b0;
        rx_packet_error = 1'b0;
        tx_done         = 1'b0;
        while (cyc < due) begin
            @(posedge clk); #1;
        end
    endtask

    // Optionally fire packets while waiting for tx, then release with tx_done
    task automatic finish_tx(input int ndrops, input int idle);
        int k;
        for (int n = 0; n < ndrops; n++) begin
            k = $urandom_range(0, 2);
            rx_packet_done  = (k != 1);
            rx_packet_error = (k != 0);
            @(posedge clk); #1;
            rx_packet_done  = 1'b0;
            rx_packet_error = 1'b0;
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
        repeat (idle) begin
            @(posedge clk); #1;
        end
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < NR; i++) if (out_regs[32*i +: 32] !== 32'd0) bad = i;
        chk({tag, "_tx_packet_wr"}, tx_packet_wr, 1'b0);
        chk({tag, "_tx_payload_len"}, tx_payload_len, 8'd0);
        chk({tag, "_tx_buf"}, tx_buf, '0);
        chk({tag, "_out_wr_stb"}, out_wr_stb, '0);
        chk({tag, "_drop_count"}, drop_count, 16'd0);
        chk({tag, "_out_regs"}, out_regs[32*bad +: 32], 32'd0);
    endtask

    // Reset while a PING is in S_EXEC (extra=0) or S_WAIT_TX (extra=1)
    task automatic reset_mid(input int extra);
        logic [7:0] b [6];
        b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        @(posedge clk); #1;
        model_cmd(1'b0, 8'd1, b);
        due = cyc + 3;
        rx_buf = '0; rx_buf[7:0] = 8'h01; rx_payload_len = 8'd1; rx_packet_done = 1'b1;
        @(posedge clk); #1;
        rx_packet_done = 1'b0;
        @(posedge clk); #1;
        repeat (extra) begin
            @(posedge clk); #1;
        end
        #1 rst_n = 1'b0;
        #1 check_all_zero(extra == 0 ? "rst_exec" : "rst_wait");
        model_reset();
        @(posedge clk); #3 rst_n = 1'b1;
        send(1'b0, 1'b1, 8'd1, b, 1'b0);
        chk("post_rst_ping_len", tx_payload_len, 8'd1);
        chk("post_rst_ping_b0", tx_buf[7:0], 8'h81);
        finish_tx(0, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [7:0] b [6];
        int         r, sel, ix;
        bit         err, dn;
        logic [7:0] len, op;

        model_reset();
        status_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        #23;
        check_all_zero("reset");
        rst_n = 1'b1;
        checking = 1'b1;

        // PING, reply held while tx_done is withheld, three busy drops
        b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send(1'b0, 1'b1, 8'd1, b, 1'b0);
        chk("ping_len", tx_payload_len, 8'd1);
        chk("ping_b0", tx_buf[7:0], 8'h81);
        repeat (4) begin @(posedge clk); #1; end
        chk("ping_hold_b0", tx_buf[7:0], 8'h81);
        finish_tx(3, 1);
        chk("drops_lit", drop_count, 16'd3);

        b = '{8'h03, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        send(1'b0, 1'b1, 8'd2, b, 1'b0);
        chk("read_drop_lit", tx_buf[47:0], 48'h03_00_00_00_FF_83);
        finish_tx(0, 0);

        b = '{8'h02, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send(1'b0, 1'b1, 8'd6, b, 1'b0);
        chk("write_lit", tx_buf[15:0], 16'h05_82);
        chk("write_stb_lit", out_wr_stb, 32'h0000_0020);
        chk("write_reg_lit", out_regs[32*5 +: 32], 32'hDEADBEEF);
        finish_tx(0, 0);

        b = '{8'h03, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        send(1'b0, 1'b1, 8'd2, b, 1'b0);
        chk("read_lit", tx_buf[47:0], 48'hEF_BE_AD_DE_05_83);
        chk("read_len_lit", tx_payload_len, 8'd6);
        finish_tx(0, 0);

        status_in[32*2 +: 32] = 32'h12345678;
        b = '{8'h03, 8'h82, 8'h00, 8'h00, 8'h00, 8'h00};
        send(1'b0, 1'b1, 8'd2, b, 1'b0);
        chk("status_lit", tx_buf[47:0], 48'h78_56_34_12_82_83);
        finish_tx(0, 0);

        b = '{8'h02, 8'(NR), 8'h11, 8'h22, 8'h33, 8'h44};
        send(1'b0, 1'b1, 8'd6, b, 1'b0);
        chk("err_idx_lit", tx_buf[15:0], 16'h03_80);
        finish_tx(0, 0);

        b = '{8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send(1'b0, 1'b1, 8'd3, b, 1'b0);
        chk("err_op_lit", tx_buf[15:0], 16'h04_80);
        finish_tx(0, 0);

        b = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        send(1'b0, 1'b1, 8'd3, b, 1'b0);
        chk("err_len_lit", tx_buf[15:0], 16'h02_80);
        finish_tx(0, 0);

        send(1'b1, 1'b0, 8'd1, b, 1'b0);
        chk("err_rx_lit", tx_buf[15:0], 16'h01_80);
        finish_tx(0, 0);

        b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send(1'b1, 1'b1, 8'd1, b, 1'b1);
        chk("err_both_lit", tx_buf[15:0], 16'h01_80);
        finish_tx(0, 0);

        // Randomized command traffic
        for (int t = 0; t < 200; t++) begin
            r   = $urandom_range(0, 99);
            err = (r < 6);
            dn  = !err || (r < 3);
            sel = $urandom_range(0, 9);
            op  = (sel < 3) ? 8'h02 : (sel < 6) ? 8'h03 : (sel < 8) ? 8'h01 :
                  (sel == 8) ? 8'h00 : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) < 8)
                len = (op == 8'h02) ? 8'($urandom_range(6, BB)) :
                      (op == 8'h03) ? 8'($urandom_range(2, BB)) : 8'($urandom_range(1, BB));
            else
                len = 8'($urandom_range(0, 5));
            sel = $urandom_range(0, 9);
            ix  = (sel < 5) ? $urandom_range(0, NR-1) :
                  (sel == 5) ? $urandom_range(NR, 127) :
                  (sel < 8) ? $urandom_range(128, 128+NS-1) :
                  (sel == 8) ? $urandom_range(128+NS, 254) : 255;
            b = '{op, 8'(ix), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
            if ($urandom_range(0, 4) == 0) status_in[32*$urandom_range(0, NS-1) +: 32] = $urandom;
            send(err, dn, len, b, $urandom_range(0, 3) == 0);
            finish_tx(($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0, $urandom_range(0, 2));
        end

        reset_mid(0);
        reset_mid(1);

        repeat (2) begin @(posedge clk); #1; end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmd_executor.md
Name: cmd_executor

Overview:
Parametrised successor of the single-reply packet executor. Decodes received command packets (ping, write register, read register) against a configurable bank of 32-bit control registers plus read-only status inputs, and queues one reply packet per command to the tx packetiser. Sits between the rx packet parser and the tx packet builder; out_regs fan out to the motion blocks.

Parameters:
NUM_REGS, 32, number of 32-bit writable control registers (1..127)
NUM_STATUS, 8, number of 32-bit read-only status inputs (0..64)
BUF_BYTES, 16, rx/tx payload buffer size in bytes (>=6)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_packet_done  in  1  one-cycle pulse: valid packet in rx_buf
rx_packet_error  in  1  one-cycle pulse: corrupt packet received
rx_payload_len  in  8  payload length of current packet
rx_buf  in  8*BUF_BYTES  payload; byte k at [8k+7:8k]
status_in  in  32*NUM_STATUS  read-only status words
tx_done  in  1  one-cycle pulse: tx builder finished current reply
tx_packet_wr  out  1  one-cycle pulse: tx_payload_len/tx_buf valid
tx_payload_len  out  8  reply length
tx_buf  out  8*BUF_BYTES  reply payload, same byte packing
out_regs  out  32*NUM_REGS  control registers, reg i at [32i+31:32i]
out_wr_stb  out  NUM_REGS  one-cycle pulse per register written
drop_count  out  16  saturating count of packets dropped while busy

Behaviour:
- Reset (rst_n low, async): state S_IDLE; all outputs, out_regs, decode latches and drop_count = 0.
- States: S_IDLE, S_DECODE, S_EXEC, S_WAIT_TX.
- S_IDLE: rx_packet_error -> latch error code 0x01, go S_EXEC. Else rx_packet_done -> latch rx_payload_len and bytes 0..5 of rx_buf, go S_DECODE. Both same cycle: error wins.
- S_DECODE (1 cycle): check opcode/length/index, form result; go S_EXEC.
- S_EXEC (1 cycle): apply write, load tx fields, pulse tx_packet_wr; go S_WAIT_TX. Latency rx_packet_done -> tx_packet_wr = 3 rising edges.
- S_WAIT_TX: tx_done -> S_IDLE. tx_done in any other state ignored.
- tx_payload_len/tx_buf hold their value until the next S_EXEC; unused tx bytes = 0.
- Commands (byte0 = opcode):
  0x01 PING, len>=1 -> reply len 1: 0x81.
  0x02 WRITE, len>=6: byte1 = index, bytes2..5 = data big-endian (byte2 = MSB); index<NUM_REGS -> out_regs[index] updated in S_EXEC, out_wr_stb[index] pulses same cycle; reply len 2: 0x82, index.
  0x03 READ, len>=2: index<NUM_REGS -> out_regs[index]; 0x80<=index<0x80+NUM_STATUS -> status_in[index-0x80]; index 0xFF -> {16'h0, drop_count}; reply len 6: 0x83, index, data big-endian. Data sampled in S_EXEC.
- Errors: reply len 2: 0x80, code. 0x01 rx_packet_error; 0x02 length too short; 0x03 index out of range (no register modified, no strobe); 0x04 unknown opcode; len 0 -> 0x02.
- Busy drop: rx_packet_done or rx_packet_error while not S_IDLE -> packet discarded, drop_count += 1, saturating at 0xFFFF; no reply. Cleared only by reset.
- Reset mid-operation: immediate return to S_IDLE, any pending reply lost, tx_packet_wr low.

Decomposition:
- Package cmd_executor_pkg: opcode constants (0x01..0x03), reply header bytes (0x80..0x83), error codes (0x01..0x04), status index base 0x80, drop-count index 0xFF, state encoding.
- One sub-module natural: cmd_reg_bank (NUM_REGS x 32 registers, write port with index/data/enable, strobe vector, read mux incl. status and drop_count).

Test Plan:
- PING: rx_buf0=0x01, len=1, done pulse -> tx_packet_wr 3 edges later, len=1, tx_buf0=0x81; no tx_done -> stays S_WAIT_TX.
- WRITE/READ: write idx 5 data 0xDEADBEEF -> out_regs[5]=0xDEADBEEF, out_wr_stb[5] one cycle, reply 0x82,0x05; then read idx 5 -> 0x83,0x05,DE,AD,BE,EF.
- Status read: status_in[2]=0x12345678, read idx 0x82 -> 0x83,0x82,12,34,56,78.
- Errors: write idx NUM_REGS -> 0x80,0x03, out_regs unchanged; opcode 0x7E -> 0x80,0x04; write with len 3 -> 0x80,0x02; rx_packet_error -> 0x80,0x01.
- Busy drop: 3 done pulses during S_WAIT_TX -> no extra replies, drop_count=3; read idx 0xFF -> 0x83,0xFF,00,00,00,03; simultaneous done+error in S_IDLE -> 0x80,0x01.
- Async reset in S_EXEC/S_WAIT_TX -> all outputs 0 without clock edge, next PING answered normally.
